rnn_step_sequencer: RTL and testbench
=====================================

# rnn_step_sequencer

Sequences one recurrent time step of the RNN accelerator. Once the parameter tensors are loaded, it walks the input, hidden, recurrent-weight, recurrent-bias and dense tensors through a single internal MAC and computes h' = act(W0·x + W1·h + b). It writes h' back into the hidden tensor and produces the scalar output y = dense·h' + dense_bias. It sits between the top-level rnn controller (which issues start when the controller leaves READY) and the tensor storage modules, whose read ports are combinational.

## Interface
- IN_LEN, default 2: input vector length.
- HID_LEN, default 4: hidden vector length; W1 is HID_LEN×HID_LEN, W0 is HID_LEN×IN_LEN.
- FRAC, default 8: fractional bits of the signed 16-bit fixed-point format (1.0 = 0x0100).
- ACC_W, default 40: signed accumulator width.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request one step; sampled only in IDLE.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  one-cycle pulse in DONE.
- x_sel  out  4  input tensor select.
- x_data  in  16  input element (same-cycle).
- h_sel  out  4  hidden tensor read select.
- h_data  in  16  hidden element.
- w0_sel_r, w0_sel_c  out  4,4  W0 row/col.
- w0_data  in  16  W0 element.
- w1_sel_r, w1_sel_c  out  4,4  W1 row/col.
- w1_data  in  16  W1 element.
- b_sel  out  4  recurrent bias select.
- b_data  in  16  bias element.
- d_sel  out  4  dense vector select.
- d_data  in  16  dense element.
- dense_bias  in  16  dense scalar bias.
- h_wr  out  1  hidden write strobe.
- h_wsel  out  4  hidden write select.
- h_wdata  out  16  hidden write data.
- y_out  out  16  step output; holds until the next DONE.

## Operation
- States and transitions:
  - IDLE → ROW_INIT on start.
  - ROW_INIT → MAC_X.
  - MAC_X (IN_LEN cycles) → MAC_H.
  - MAC_H (HID_LEN cycles) → ACT.
  - ACT → ROW_INIT while row < HID_LEN-1, else WB.
  - WB (HID_LEN cycles) → D_INIT.
  - D_INIT → D_MAC.
  - D_MAC (HID_LEN cycles) → D_FIN.
  - D_FIN → DONE.
  - DONE → IDLE.
- ROW_INIT:
  - Drives b_sel = row.
  - Loads acc = sign-extended b_data << FRAC.
- MAC_X, cycle j:
  - Drives x_sel = j, w0_sel_r = row, w0_sel_c = j.
  - acc += x_data × w0_data (full 32-bit signed product).
- MAC_H, cycle j:
  - Drives h_sel = j, w1_sel_r = row, w1_sel_c = j.
  - acc += h_data × w1_data.
  - Reads always see the old h, because the new values are buffered internally.
- ACT:
  - r = (acc + (1 << (FRAC-1))) >>> FRAC, which is round-half-up.
  - r is saturated to [-32768, 32767], then the activation is applied (see Configuration).
  - The result is stored in internal buffer hbuf[row].
- WB:
  - h_wr = 1, h_wsel = k, h_wdata = hbuf[k] for k = 0..HID_LEN-1.
  - This is the only state in which h_wr is asserted.
- D_INIT:
  - acc = sign-extended dense_bias << FRAC.
- D_MAC, cycle k:
  - d_sel = k.
  - acc += hbuf[k] × d_data.
- D_FIN:
  - Same round and saturate as ACT, with no activation.
  - The result is registered into y_out.
- Unused select outputs hold 0 outside their states.
- start is ignored while busy and in DONE; no queuing.
- Reset values:
  - State IDLE.
  - busy, done, h_wr = 0.
  - All selects, h_wdata and y_out = 0.
  - hbuf and acc = 0.
- Reset mid-step aborts the step immediately:
  - No further h_wr pulses are issued.
  - y_out is cleared.
  - The hidden tensor keeps whatever rows were already written.

## Timing
- Compute latency L = HID_LEN·(IN_LEN+HID_LEN+2) + 2·HID_LEN + 2.
  - With default parameters, L = 42.
- If start is sampled at edge k:
  - busy is high for cycles k+1 … k+L.
  - done and the updated y_out are visible in cycle k+L+1.
  - IDLE resumes at k+L+2.
- Back-to-back steps: a start held high through DONE is accepted on the first IDLE cycle.
- Tensor reads are combinational; data is consumed on the same edge the select is driven.

## Configuration
- RNN_SEQ_HARDTANH_EN
  - Defined: ACT clips r to [-(1<<FRAC), (1<<FRAC)], i.e. ±1.0.
  - Undefined: activation is identity, so h' equals the 16-bit-saturated r.
  - The dense output is never clipped in either case.

## Test plan
All scenarios use the default parameters unless stated otherwise.
- Identity pass:
  - Stimulus: x=[0x0100,0x0200], W0 rows=[0x0100,0], W1=0, b=0, dense=[0x0100]×4, dense_bias=0.
  - Response: h_wdata=0x0100 ×4 and y_out=0x0400 at cycle k+43.
- Clipping:
  - Stimulus: W0 all 0x7FFF, x=[0x7FFF,0x7FFF].
  - Response: h=0x0100 with RNN_SEQ_HARDTANH_EN, 0x7FFF without; y_out saturates to 0x7FFF when dense=[0x7FFF]×4.
- Rounding:
  - Stimulus: IN_LEN=1 build, x=[0x0001], W0=[0x0080], rest 0.
  - Response: h[0]=0x0001 (half rounds up). With W0=[0xFF80]: h[0]=0x0000.
- Recurrence uses old h:
  - Stimulus: W1 = shift matrix (row i col i-1 = 0x0100), h=[1,2,3,4]·0x0100, W0=0, b=0.
  - Response: new h=[0,1,2,3]·0x0100 (with the macro: [0,0x0100,0x0100,0x0100]).
- Ignored start:
  - Stimulus: start pulsed at cycles k+5 and k+42.
  - Response: exactly one done, exactly 4 h_wr pulses.
- Reset mid-op:
  - Stimulus: rst_n low at cycle k+20.
  - Response: busy=0, y_out=0, no h_wr seen; the next start produces the full 42-cycle step.

Source files
------------

// File: rtl/rnn_step_sequencer_if.sv
`default_nettype none
// ============================================================================
// rnn_step_sequencer_if : handshake and tensor-port bundle of the RNN step
//                         sequencer (master = sequencer, slave = storage/ctrl)
// Revision: 1.0
// ============================================================================
interface rnn_step_sequencer_if;
    logic        start;
    logic        busy;
    logic        done;
    logic [3:0]  x_sel;
    logic [15:0] x_data;
    logic [3:0]  h_sel;
    logic [15:0] h_data;
    logic [3:0]  w0_sel_r;
    logic [3:0]  w0_sel_c;
    logic [15:0] w0_data;
    logic [3:0]  w1_sel_r;
    logic [3:0]  w1_sel_c;
    logic [15:0] w1_data;
    logic [3:0]  b_sel;
    logic [15:0] b_data;
    logic [3:0]  d_sel;
    logic [15:0] d_data;
    logic [15:0] dense_bias;
    logic        h_wr;
    logic [3:0]  h_wsel;
    logic [15:0] h_wdata;
    logic [15:0] y_out;

    modport master (
        input  start, x_data, h_data, w0_data, w1_data, b_data, d_data, dense_bias,
        output busy, done, x_sel, h_sel, w0_sel_r, w0_sel_c, w1_sel_r, w1_sel_c,
               b_sel, d_sel, h_wr, h_wsel, h_wdata, y_out
    );

    modport slave (
        output start, x_data, h_data, w0_data, w1_data, b_data, d_data, dense_bias,
        input  busy, done, x_sel, h_sel, w0_sel_r, w0_sel_c, w1_sel_r, w1_sel_c,
               b_sel, d_sel, h_wr, h_wsel, h_wdata, y_out
    );
endinterface
`default_nettype wire

// File: rtl/rnn_step_sequencer.sv
`default_nettype none
// ============================================================================
// rnn_step_sequencer : one RNN time step h' = act(W0.x + W1.h + b), y = d.h' + db
//                      on a single shared MAC. Option macro: RNN_SEQ_HARDTANH_EN
// Revision: 1.0
// ============================================================================
module rnn_step_sequencer #(
    parameter int IN_LEN  = 2,
    parameter int HID_LEN = 4,
    parameter int FRAC    = 8,
    parameter int ACC_W   = 40
) (
    input wire logic             clk,
    input wire logic             rst_n,
    rnn_step_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ROW_INIT = 4'd1,
        MAC_X    = 4'd2,
        MAC_H    = 4'd3,
        ACT      = 4'd4,
        WB       = 4'd5,
        D_INIT   = 4'd6,
        D_MAC    = 4'd7,
        D_FIN    = 4'd8,
        DONE     = 4'd9
    } state_t;

    localparam int                      HIDX_W   = (HID_LEN > 1) ? $clog2(HID_LEN) : 1;
    localparam logic [3:0]              IN_LAST  = 4'(IN_LEN - 1);
    localparam logic [3:0]              HID_LAST = 4'(HID_LEN - 1);
    localparam logic signed [ACC_W-1:0] ROUND_K  = ACC_W'(1) <<< (FRAC - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-32768);
    localparam logic signed [15:0]      CLIP_MAX = 16'(1 << FRAC);
    localparam logic signed [15:0]      CLIP_MIN = -CLIP_MAX;

    state_t                  state, state_next;
    logic [3:0]              cnt, row;
    logic [HIDX_W-1:0]       cnt_idx, row_idx;
    logic signed [ACC_W-1:0] acc, acc_sum, acc_rnd;
    logic signed [15:0]      mac_a, mac_b, sat_val, act_val, y_reg;
    logic signed [31:0]      prod;
    logic signed [15:0]      hbuf [HID_LEN];

    assign cnt_idx   = cnt[HIDX_W-1:0];
    assign row_idx   = row[HIDX_W-1:0];
    assign prod      = mac_a * mac_b;
    assign acc_sum   = acc + ACC_W'(prod);
    assign acc_rnd   = (acc + ROUND_K) >>> FRAC;
    assign bus.y_out = y_reg;

    always_comb begin
        if (acc_rnd > SAT_MAX)      sat_val = 16'sh7FFF;
        else if (acc_rnd < SAT_MIN) sat_val = 16'sh8000;
        else                        sat_val = acc_rnd[15:0];
    end

`ifdef RNN_SEQ_HARDTANH_EN
    always_comb begin
        if (sat_val > CLIP_MAX)      act_val = CLIP_MAX;
        else if (sat_val < CLIP_MIN) act_val = CLIP_MIN;
        else                         act_val = sat_val;
    end
`else
    assign act_val = sat_val;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Selects are decoded from state so storage reads resolve within the cycle.
    always_comb begin
        state_next   = state;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.x_sel    = '0;
        bus.h_sel    = '0;
        bus.w0_sel_r = '0;
        bus.w0_sel_c = '0;
        bus.w1_sel_r = '0;
        bus.w1_sel_c = '0;
        bus.b_sel    = '0;
        bus.d_sel    = '0;
        bus.h_wr     = 1'b0;
        bus.h_wsel   = '0;
        bus.h_wdata  = '0;
        mac_a        = '0;
        mac_b        = '0;
        case (state)
            IDLE: if (bus.start) state_next = ROW_INIT;
            ROW_INIT: begin
                bus.busy   = 1'b1;
                bus.b_sel  = row;
                state_next = MAC_X;
            end
            MAC_X: begin
                bus.busy     = 1'b1;
                bus.x_sel    = cnt;
                bus.w0_sel_r = row;
                bus.w0_sel_c = cnt;
                mac_a        = bus.x_data;
                mac_b        = bus.w0_data;
                if (cnt == IN_LAST) state_next = MAC_H;
            end
            MAC_H: begin
                bus.busy     = 1'b1;
                bus.h_sel    = cnt;
                bus.w1_sel_r = row;
                bus.w1_sel_c = cnt;
                mac_a        = bus.h_data;
                mac_b        = bus.w1_data;
                if (cnt == HID_LAST) state_next = ACT;
            end
            ACT: begin
                bus.busy   = 1'b1;
                state_next = (row == HID_LAST) ? WB : ROW_INIT;
            end
            WB: begin
                bus.busy    = 1'b1;
                bus.h_wr    = 1'b1;
                bus.h_wsel  = cnt;
                bus.h_wdata = hbuf[cnt_idx];
                if (cnt == HID_LAST) state_next = D_INIT;
            end
            D_INIT: begin
                bus.busy   = 1'b1;
                state_next = D_MAC;
            end
            D_MAC: begin
                bus.busy  = 1'b1;
                bus.d_sel = cnt;
                mac_a     = hbuf[cnt_idx];
                mac_b     = bus.d_data;
                if (cnt == HID_LAST) state_next = D_FIN;
            end
            D_FIN: begin
                bus.busy   = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            row   <= '0;
            y_reg <= '0;
            for (int i = 0; i < HID_LEN; i++) hbuf[i] <= '0;
        end else begin
            // cnt is the position inside the current multi-cycle phase
            cnt <= (state_next != state || state == IDLE) ? 4'd0 : cnt + 4'd1;
            case (state)
                IDLE:               row <= '0;
                ROW_INIT:           acc <= ACC_W'($signed(bus.b_data)) <<< FRAC;
                MAC_X, MAC_H, D_MAC: acc <= acc_sum;
                ACT: begin
                    hbuf[row_idx] <= act_val;
                    row           <= row + 4'd1;
                end
                D_INIT:             acc   <= ACC_W'($signed(bus.dense_bias)) <<< FRAC;
                D_FIN:              y_reg <= sat_val;
                default:            ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_rnn_step_sequencer.sv
`default_nettype none
// ============================================================================
// tb_rnn_step_sequencer : randomized self-checking bench with tensor storage
//                         and an arithmetic reference model of one RNN step
// Revision: 1.0
// ============================================================================
module tb_rnn_step_sequencer;
    localparam int IN_LEN  = 2;
    localparam int HID_LEN = 4;
    localparam int FRAC    = 8;
    localparam int LAT     = HID_LEN * (IN_LEN + HID_LEN + 2) + 2 * HID_LEN + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rnn_step_sequencer_if bus ();

    rnn_step_sequencer #(
        .IN_LEN (IN_LEN),
        .HID_LEN(HID_LEN),
        .FRAC   (FRAC),
        .ACC_W  (40)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] xmem [16];
    logic [15:0] hmem [16];
    logic [15:0] bmem [16];
    logic [15:0] dmem [16];
    logic [15:0] w0mem [16][16];
    logic [15:0] w1mem [16][16];
    logic [15:0] dbias;
    logic        tb_wr = 1'b0;
    logic [3:0]  tb_wsel = '0;
    logic [15:0] tb_wdata = '0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic signed [15:0] mh [HID_LEN];
    logic [15:0]        exp_y;

    assign bus.x_data     = xmem[bus.x_sel];
    assign bus.h_data     = hmem[bus.h_sel];
    assign bus.b_data     = bmem[bus.b_sel];
    assign bus.d_data     = dmem[bus.d_sel];
    assign bus.w0_data    = w0mem[bus.w0_sel_r][bus.w0_sel_c];
    assign bus.w1_data    = w1mem[bus.w1_sel_r][bus.w1_sel_c];
    assign bus.dense_bias = dbias;

    always @(posedge clk) begin
        if (bus.done) done_cnt++;
        if (bus.h_wr) begin
            hmem[bus.h_wsel] <= bus.h_wdata;
            wr_cnt++;
        end else if (tb_wr) begin
            hmem[tb_wsel] <= tb_wdata;
        end
    end

    // ---------------- reference model ----------------
    function automatic longint sx(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint rnd_sat(input longint a);
        longint r;
        r = (a + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        return r;
    endfunction

    task automatic model_step();
        longint acc;
        longint nh [HID_LEN];
        for (int i = 0; i < HID_LEN; i++) begin
            acc = sx(bmem[i]) * (longint'(1) << FRAC);
            for (int j = 0; j < IN_LEN; j++)  acc += sx(xmem[j]) * sx(w0mem[i][j]);
            for (int j = 0; j < HID_LEN; j++) acc += longint'(mh[j]) * sx(w1mem[i][j]);
            nh[i] = rnd_sat(acc);
`ifdef RNN_SEQ_HARDTANH_EN
            if (nh[i] > (1 << FRAC)) nh[i] = 1 << FRAC;
            if (nh[i] < -(1 << FRAC)) nh[i] = -(1 << FRAC);
`endif
        end
        for (int i = 0; i < HID_LEN; i++) mh[i] = 16'(nh[i]);
        acc = sx(dbias) * (longint'(1) << FRAC);
        for (int k = 0; k < HID_LEN; k++) acc += longint'(mh[k]) * sx(dmem[k]);
        exp_y = 16'(rnd_sat(acc));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_all();
        for (int i = 0; i < 16; i++) begin
            xmem[i] = '0; bmem[i] = '0; dmem[i] = '0;
            for (int j = 0; j < 16; j++) begin
                w0mem[i][j] = '0; w1mem[i][j] = '0;
            end
        end
        dbias = '0;
        for (int i = 0; i < HID_LEN; i++) mh[i] = '0;
    endtask

    function automatic logic [15:0] rval(input bit big);
        if (big) return 16'($urandom);
        return 16'($urandom_range(0, 1023)) - 16'd512;
    endfunction

    task automatic rand_all(input bit big);
        for (int i = 0; i < HID_LEN; i++) begin
            bmem[i] = rval(big); dmem[i] = rval(big); mh[i] = rval(big);
            for (int j = 0; j < IN_LEN; j++)  w0mem[i][j] = rval(big);
            for (int j = 0; j < HID_LEN; j++) w1mem[i][j] = rval(big);
        end
        for (int j = 0; j < IN_LEN; j++) xmem[j] = rval(big);
        dbias = rval(big);
    endtask

    // Loads the model's hidden vector into the tensor store while the DUT idles.
    task automatic sync_hidden();
        for (int i = 0; i < HID_LEN; i++) begin
            tb_wr = 1'b1; tb_wsel = 4'(i); tb_wdata = mh[i];
            @(posedge clk); #1;
        end
        tb_wr = 1'b0;
    endtask

    task automatic run_step(output int lat, output int gaps, output logic [15:0] y_done,
                            output logic [15:0] y_hold, output logic idle_after);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1; gaps = 0; y_done = 'x;
        for (int m = 1; m <= LAT + 20; m++) begin
            if (bus.done) begin
                lat = m; y_done = bus.y_out;
                break;
            end
            if (!bus.busy) gaps++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        y_hold = bus.y_out;
        idle_after = !bus.busy && !bus.done;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; bus.start = 1'b0;
        clear_all();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_checks++; if (bus.h_wr !== 1'b0) begin n_fail++; $display("FAIL reset_h_wr: got %b expected 0", bus.h_wr); end
        n_checks++; if (bus.y_out !== 16'h0) begin n_fail++; $display("FAIL reset_y_out: got %h expected 0000", bus.y_out); end
        n_checks++;
        if ({bus.x_sel, bus.h_sel, bus.b_sel, bus.d_sel, bus.w0_sel_r, bus.w1_sel_c, bus.h_wsel, bus.h_wdata} !== 44'h0) begin
            n_fail++; $display("FAIL reset_selects: got %h expected 0", {bus.x_sel, bus.h_sel, bus.b_sel, bus.d_sel, bus.h_wsel, bus.h_wdata});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_identity();
        int lat, gaps, wr0; logic [15:0] yd, yh; logic idle;
        clear_all();
        xmem[0] = 16'h0100; xmem[1] = 16'h0200;
        for (int i = 0; i < HID_LEN; i++) begin w0mem[i][0] = 16'h0100; dmem[i] = 16'h0100; end
        sync_hidden();
        model_step();
        wr0 = wr_cnt;
        run_step(lat, gaps, yd, yh, idle);
        n_checks++; if (lat !== LAT + 1) begin n_fail++; $display("FAIL identity_latency: got %0d expected %0d", lat, LAT + 1); end
        n_checks++; if (gaps !== 0) begin n_fail++; $display("FAIL identity_busy_gaps: got %0d expected 0", gaps); end
        n_checks++; if (wr_cnt - wr0 !== HID_LEN) begin n_fail++; $display("FAIL identity_wr_count: got %0d expected %0d", wr_cnt - wr0, HID_LEN); end
        for (int i = 0; i < HID_LEN; i++) begin
            n_checks++; if (hmem[i] !== 16'h0100) begin n_fail++; $display("FAIL identity_h%0d: got %h expected 0100", i, hmem[i]); end
        end
        n_checks++; if (yd !== 16'h0400) begin n_fail++; $display("FAIL identity_y: got %h expected 0400", yd); end
        n_checks++; if (yh !== 16'h0400) begin n_fail++; $display("FAIL identity_y_hold: got %h expected 0400", yh); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL identity_idle_after: got %b expected 1", idle); end
    endtask

    task automatic test_clipping();
        int lat, gaps; logic [15:0] yd, yh, hexp; logic idle;
        clear_all();
`ifdef RNN_SEQ_HARDTANH_EN
        hexp = 16'h0100;
`else
        hexp = 16'h7FFF;
`endif
        for (int j = 0; j < IN_LEN; j++) xmem[j] = 16'h7FFF;
        for (int i = 0; i < HID_LEN; i++) begin
            dmem[i] = 16'h7FFF;
            for (int j = 0; j < IN_LEN; j++) w0mem[i][j] = 16'h7FFF;
        end
        sync_hidden();
        model_step();
        run_step(lat, gaps, yd, yh, idle);
        for (int i = 0; i < HID_LEN; i++) begin
            n_checks++; if (hmem[i] !== hexp) begin n_fail++; $display("FAIL clip_h%0d: got %h expected %h", i, hmem[i], hexp); end
        end
        n_checks++; if (yd !== 16'h7FFF) begin n_fail++; $display("FAIL clip_y: got %h expected 7fff", yd); end
    endtask

    task automatic test_rounding();
        int lat, gaps; logic [15:0] yd, yh; logic idle;
        clear_all();
        xmem[0] = 16'h0001; w0mem[0][0] = 16'h0080;
        sync_hidden();
        model_step();
        run_step(lat, gaps, yd, yh, idle);
        n_checks++; if (hmem[0] !== 16'h0001) begin n_fail++; $display("FAIL round_half_up: got %h expected 0001", hmem[0]); end
        w0mem[0][0] = 16'hFF80;
        model_step();
        run_step(lat, gaps, yd, yh, idle);
        n_checks++; if (hmem[0] !== 16'h0000) begin n_fail++; $display("FAIL round_neg_half: got %h expected 0000", hmem[0]); end
        n_checks++; if (yd !== exp_y) begin n_fail++; $display("FAIL round_y: got %h expected %h", yd, exp_y); end
    endtask

    task automatic test_recurrence();
        int lat, gaps; logic [15:0] yd, yh; logic [15:0] hexp [HID_LEN]; logic idle;
        clear_all();
        for (int i = 0; i < HID_LEN; i++) begin
            mh[i] = 16'((i + 1) * 256); dmem[i] = 16'h0100;
            if (i > 0) w1mem[i][i-1] = 16'h0100;
        end
`ifdef RNN_SEQ_HARDTANH_EN
        hexp = '{16'h0000, 16'h0100, 16'h0100, 16'h0100};
`else
        hexp = '{16'h0000, 16'h0100, 16'h0200, 16'h0300};
`endif
        sync_hidden();
        model_step();
        run_step(lat, gaps, yd, yh, idle);
        for (int i = 0; i < HID_LEN; i++) begin
            n_checks++; if (hmem[i] !== hexp[i]) begin n_fail++; $display("FAIL recur_h%0d: got %h expected %h", i, hmem[i], hexp[i]); end
        end
        n_checks++; if (yd !== exp_y) begin n_fail++; $display("FAIL recur_y: got %h expected %h", yd, exp_y); end
    endtask

    task automatic test_random();
        int lat, gaps; logic [15:0] yd, yh; logic idle;
        for (int it = 0; it < 10; it++) begin
            rand_all(it[0]);
            sync_hidden();
            model_step();
            run_step(lat, gaps, yd, yh, idle);
            n_checks++; if (lat !== LAT + 1) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", it, lat, LAT + 1); end
            for (int i = 0; i < HID_LEN; i++) begin
                n_checks++; if (hmem[i] !== mh[i]) begin n_fail++; $display("FAIL rand%0d_h%0d: got %h expected %h", it, i, hmem[i], mh[i]); end
            end
            n_checks++; if (yd !== exp_y) begin n_fail++; $display("FAIL rand%0d_y: got %h expected %h", it, yd, exp_y); end
        end
    endtask

    task automatic test_ignored_start();
        int d0, w0c, first_done;
        rand_all(1'b0);
        sync_hidden();
        model_step();
        d0 = done_cnt; w0c = wr_cnt; first_done = -1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int m = 1; m <= LAT + 18; m++) begin
            if (bus.done && first_done < 0) first_done = m;
            bus.start = (m == 5 || m == LAT);
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL ignored_done_count: got %0d expected 1", done_cnt - d0); end
        n_checks++; if (wr_cnt - w0c !== HID_LEN) begin n_fail++; $display("FAIL ignored_wr_count: got %0d expected %0d", wr_cnt - w0c, HID_LEN); end
        n_checks++; if (first_done !== LAT + 1) begin n_fail++; $display("FAIL ignored_done_cycle: got %0d expected %0d", first_done, LAT + 1); end
        n_checks++; if (bus.y_out !== exp_y) begin n_fail++; $display("FAIL ignored_y: got %h expected %h", bus.y_out, exp_y); end
    endtask

    task automatic test_back_to_back();
        int dc [2]; int nd; logic [15:0] yv [2]; logic [15:0] y1;
        rand_all(1'b0);
        sync_hidden();
        model_step();
        y1 = exp_y;
        model_step();
        nd = 0; dc = '{-1, -1}; yv = '{16'hxxxx, 16'hxxxx};
        bus.start = 1'b1;
        @(posedge clk); #1;
        for (int m = 1; m <= 3 * LAT && nd < 2; m++) begin
            if (bus.done) begin dc[nd] = m; yv[nd] = bus.y_out; nd++; end
            if (m == LAT + 3) bus.start = 1'b0;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (dc[0] !== LAT + 1) begin n_fail++; $display("FAIL b2b_first_done: got %0d expected %0d", dc[0], LAT + 1); end
        n_checks++; if (dc[1] !== 2 * LAT + 3) begin n_fail++; $display("FAIL b2b_second_done: got %0d expected %0d", dc[1], 2 * LAT + 3); end
        n_checks++; if (yv[0] !== y1) begin n_fail++; $display("FAIL b2b_y1: got %h expected %h", yv[0], y1); end
        n_checks++; if (yv[1] !== exp_y) begin n_fail++; $display("FAIL b2b_y2: got %h expected %h", yv[1], exp_y); end
        for (int i = 0; i < HID_LEN; i++) begin
            n_checks++; if (hmem[i] !== mh[i]) begin n_fail++; $display("FAIL b2b_h%0d: got %h expected %h", i, hmem[i], mh[i]); end
        end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy %b expected 0", bus.busy); end
    endtask

    task automatic test_reset_midop();
        int w0c, lat, gaps; logic [15:0] yd, yh; logic idle;
        rand_all(1'b0);
        sync_hidden();
        w0c = wr_cnt;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.y_out !== 16'h0) begin n_fail++; $display("FAIL midrst_y_out: got %h expected 0000", bus.y_out); end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (wr_cnt - w0c !== 0) begin n_fail++; $display("FAIL midrst_no_wr: got %0d expected 0", wr_cnt - w0c); end
        model_step();
        run_step(lat, gaps, yd, yh, idle);
        n_checks++; if (lat !== LAT + 1) begin n_fail++; $display("FAIL midrst_latency: got %0d expected %0d", lat, LAT + 1); end
        n_checks++; if (gaps !== 0) begin n_fail++; $display("FAIL midrst_busy_gaps: got %0d expected 0", gaps); end
        for (int i = 0; i < HID_LEN; i++) begin
            n_checks++; if (hmem[i] !== mh[i]) begin n_fail++; $display("FAIL midrst_h%0d: got %h expected %h", i, hmem[i], mh[i]); end
        end
        n_checks++; if (yd !== exp_y) begin n_fail++; $display("FAIL midrst_y: got %h expected %h", yd, exp_y); end
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_identity();
        test_clipping();
        test_rounding();
        test_recurrence();
        test_random();
        test_ignored_start();
        test_back_to_back();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
